// File: rtl/stack_if.sv
// Operation request, data-memory and architectural-update signals of the stack sequencer.
// The master modport is the decode/control side; the slave modport is stack_unit.
interface stack_if;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op;
  logic [7:0] sp_in;
  logic [7:0] push_data;
  logic [7:0] pc_plus1;
  logic [7:0] target;
  logic [3:0] flags_in;
  logic [1:0] rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic [7:0] sp_value;
  logic       sp_write_enable;
  logic       rd_we;
  logic [1:0] rd_wa;
  logic [7:0] rd_data;
  logic       pc_load;
  logic [7:0] pc_value;
  logic       flags_load;
  logic [3:0] flags_value;
  logic       done;
  logic       err;

  modport master (
    output op_valid, op, sp_in, push_data, pc_plus1, target, flags_in, rd, mem_rdata,
    input  op_ready, mem_addr, mem_wdata, mem_we, mem_re, sp_value, sp_write_enable,
           rd_we, rd_wa, rd_data, pc_load, pc_value, flags_load, flags_value, done, err
  );

  modport slave (
    input  op_valid, op, sp_in, push_data, pc_plus1, target, flags_in, rd, mem_rdata,
    output op_ready, mem_addr, mem_wdata, mem_we, mem_re, sp_value, sp_write_enable,
           rd_we, rd_wa, rd_data, pc_load, pc_value, flags_load, flags_value, done, err
  );
endinterface

// File: rtl/stack_unit.sv
// Multi-cycle stack sequencer: PUSH/POP/CALL/RET/INT/RTI against data memory, sole SP writer.
// SP grows downward; each state name describes the cycle in which its outputs are visible.
module stack_unit #(
  parameter logic [7:0] SP_TOP      = 8'hFF,
  parameter logic [7:0] STACK_LIMIT = 8'h80,
  parameter logic [7:0] IVEC_ADDR   = 8'h01
) (
  input logic    i_clk,
  input logic    i_rst,
  stack_if.slave s_if
);
  // state  | meaning
  // IDLE   | waiting for a request, op_ready=1
  // WR1    | first memory write on the bus (PUSH/CALL data, INT return PC)
  // WR2    | INT second write (saved flags)
  // RD1    | first memory read on the bus (SP+1, or the interrupt vector for INT)
  // RD2    | RTI second read (PC), flags captured at its end
  // RDV    | POP: SP committed, popped byte captured at its end
  // COMMIT | SP/PC/flags update with done
  // WB     | POP register write-back with done
  // FAULT  | done with err, nothing updated
  typedef enum logic [3:0] {
    S_IDLE, S_WR1, S_WR2, S_RD1, S_RD2, S_RDV, S_COMMIT, S_WB, S_FAULT
  } state_t;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_POP  = 3'd1;
  localparam logic [2:0] OP_CALL = 3'd2;
  localparam logic [2:0] OP_RET  = 3'd3;
  localparam logic [2:0] OP_INT  = 3'd4;
  localparam logic [2:0] OP_RTI  = 3'd5;

  state_t     r_state;
  logic [2:0] r_op;
  logic [7:0] r_sp;
  logic [7:0] r_target;
  logic [3:0] r_flags;
  logic [1:0] r_rd;

  logic [7:0] r_mem_addr, r_mem_wdata, r_sp_value, r_rd_data, r_pc_value;
  logic       r_mem_we, r_mem_re, r_sp_we, r_rd_we, r_pc_load, r_pc_from_mem;
  logic       r_flags_load, r_done, r_err;
  logic [1:0] r_rd_wa;
  logic [3:0] r_flags_value;
  logic       w_fault;

  always_comb begin
    w_fault = 1'b0;
    case (s_if.op)
      OP_PUSH, OP_CALL: w_fault = s_if.sp_in < STACK_LIMIT;
      OP_POP:           w_fault = (s_if.sp_in >= SP_TOP) || (s_if.rd == 2'd3);
      OP_RET:           w_fault = s_if.sp_in >= SP_TOP;
      OP_INT:           w_fault = s_if.sp_in <= STACK_LIMIT;
      OP_RTI:           w_fault = s_if.sp_in > (SP_TOP - 8'd2);
      default:          w_fault = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_op          <= 3'd0;
      r_sp          <= 8'd0;
      r_target      <= 8'd0;
      r_flags       <= 4'd0;
      r_rd          <= 2'd0;
      r_mem_addr    <= 8'd0;
      r_mem_wdata   <= 8'd0;
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_sp_value    <= 8'd0;
      r_sp_we       <= 1'b0;
      r_rd_we       <= 1'b0;
      r_rd_wa       <= 2'd0;
      r_rd_data     <= 8'd0;
      r_pc_load     <= 1'b0;
      r_pc_value    <= 8'd0;
      r_pc_from_mem <= 1'b0;
      r_flags_load  <= 1'b0;
      r_flags_value <= 4'd0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_mem_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_sp_we       <= 1'b0;
      r_rd_we       <= 1'b0;
      r_pc_load     <= 1'b0;
      r_pc_from_mem <= 1'b0;
      r_flags_load  <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      case (r_state)
        S_IDLE: if (s_if.op_valid) begin
          r_op     <= s_if.op;
          r_sp     <= s_if.sp_in;
          r_target <= s_if.target;
          r_flags  <= s_if.flags_in;
          r_rd     <= s_if.rd;
          if (w_fault) begin
            r_done  <= 1'b1;
            r_err   <= 1'b1;
            r_state <= S_FAULT;
          end else if (s_if.op == OP_PUSH || s_if.op == OP_CALL || s_if.op == OP_INT) begin
            r_mem_we    <= 1'b1;
            r_mem_addr  <= s_if.sp_in;
            r_mem_wdata <= (s_if.op == OP_PUSH) ? s_if.push_data : s_if.pc_plus1;
            r_state     <= S_WR1;
          end else begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= s_if.sp_in + 8'd1;
            r_state    <= S_RD1;
          end
        end
        S_WR1: if (r_op == OP_INT) begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= r_sp - 8'd1;
          r_mem_wdata <= {4'b0000, r_flags};
          r_state     <= S_WR2;
        end else begin
          r_sp_value <= r_sp - 8'd1;
          r_sp_we    <= 1'b1;
          r_pc_load  <= (r_op == OP_CALL);
          r_pc_value <= r_target;
          r_done     <= 1'b1;
          r_state    <= S_COMMIT;
        end
        S_WR2: begin
          r_mem_re   <= 1'b1;
          r_mem_addr <= IVEC_ADDR;
          r_state    <= S_RD1;
        end
        S_RD1: case (r_op)
          OP_POP: begin
            r_sp_value <= r_sp + 8'd1;
            r_sp_we    <= 1'b1;
            r_state    <= S_RDV;
          end
          OP_RTI: begin
            r_mem_re   <= 1'b1;
            r_mem_addr <= r_sp + 8'd2;
            r_state    <= S_RD2;
          end
          default: begin
            // RET or INT: the new PC is the read data arriving in the commit cycle
            r_sp_value    <= (r_op == OP_INT) ? r_sp - 8'd2 : r_sp + 8'd1;
            r_sp_we       <= 1'b1;
            r_pc_load     <= 1'b1;
            r_pc_from_mem <= 1'b1;
            r_done        <= 1'b1;
            r_state       <= S_COMMIT;
          end
        endcase
        S_RD2: begin
          r_sp_value    <= r_sp + 8'd2;
          r_sp_we       <= 1'b1;
          r_pc_load     <= 1'b1;
          r_pc_from_mem <= 1'b1;
          r_flags_load  <= 1'b1;
          r_flags_value <= s_if.mem_rdata[3:0];
          r_done        <= 1'b1;
          r_state       <= S_COMMIT;
        end
        S_RDV: begin
          r_rd_we   <= 1'b1;
          r_rd_wa   <= r_rd;
          r_rd_data <= s_if.mem_rdata;
          r_done    <= 1'b1;
          r_state   <= S_WB;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign s_if.op_ready        = (r_state == S_IDLE);
  assign s_if.mem_addr        = r_mem_addr;
  assign s_if.mem_wdata       = r_mem_wdata;
  assign s_if.mem_we          = r_mem_we;
  assign s_if.mem_re          = r_mem_re;
  assign s_if.sp_value        = r_sp_value;
  assign s_if.sp_write_enable = r_sp_we;
  assign s_if.rd_we           = r_rd_we;
  assign s_if.rd_wa           = r_rd_wa;
  assign s_if.rd_data         = r_rd_data;
  assign s_if.pc_load         = r_pc_load;
  assign s_if.pc_value        = r_pc_from_mem ? s_if.mem_rdata : r_pc_value;
  assign s_if.flags_load      = r_flags_load;
  assign s_if.flags_value     = r_flags_value;
  assign s_if.done            = r_done;
  assign s_if.err             = r_err;
endmodule

// File: tb/tb_stack_unit.sv
// Bench for stack_unit: a monitor logs every strobe with its cycle, each test pushes the
// expected strobe sequence when it drives an op and compares the two logs afterwards.
module tb_stack_unit;
  localparam logic [3:0] K_MW = 4'd1, K_MR = 4'd2, K_SP = 4'd3, K_PC = 4'd4;
  localparam logic [3:0] K_FL = 4'd5, K_RD = 4'd6, K_DN = 4'd7, K_BAD = 4'd8;

  typedef struct packed {
    logic [3:0]  k;
    logic [15:0] c;
    logic [7:0]  a;
    logic [7:0]  b;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc_cnt = 0;
  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  obs_q[$];
  logic [7:0] mem [256];

  stack_if bus ();

  stack_unit dut (
    .i_clk(clk),
    .i_rst(rst),
    .s_if (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  // data memory; address 01 is the fixed interrupt vector
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= (bus.mem_addr == 8'h01) ? 8'h20 : mem[bus.mem_addr];
  end

  function automatic ev_t ev(input logic [3:0] k, input int n, input logic [7:0] a, input logic [7:0] b);
    ev_t e;
    e.k = k;
    e.c = 16'(cyc_cnt + n);
    e.a = a;
    e.b = b;
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.mem_we) obs_q.push_back(ev(K_MW, 0, bus.mem_addr, bus.mem_wdata));
    if (bus.mem_re) obs_q.push_back(ev(K_MR, 0, bus.mem_addr, 8'h00));
    if (bus.sp_write_enable) obs_q.push_back(ev(K_SP, 0, bus.sp_value, 8'h00));
    if (bus.pc_load) obs_q.push_back(ev(K_PC, 0, bus.pc_value, 8'h00));
    if (bus.flags_load) obs_q.push_back(ev(K_FL, 0, {4'b0, bus.flags_value}, 8'h00));
    if (bus.rd_we) obs_q.push_back(ev(K_RD, 0, {6'b0, bus.rd_wa}, bus.rd_data));
    if (bus.done) obs_q.push_back(ev(K_DN, 0, {7'b0, bus.err}, 8'h00));
    if (bus.sp_write_enable && bus.rd_we) obs_q.push_back(ev(K_BAD, 0, 8'h00, 8'h00));
  end

  // Drives one request at a negedge, scrambles the operands after the accept edge and
  // waits (bounded) for done; returns op_ready in the done cycle and the cycle after.
  task automatic issue(input logic [2:0] op, input logic [7:0] sp, input logic [7:0] pd,
                       input logic [7:0] pc1, input logic [7:0] tgt, input logic [3:0] fl,
                       input logic [1:0] rd, output logic rdy_done, output logic rdy_after);
    int n;
    bus.op_valid = 1'b1; bus.op = op; bus.sp_in = sp; bus.push_data = pd;
    bus.pc_plus1 = pc1; bus.target = tgt; bus.flags_in = fl; bus.rd = rd;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = 3'd7; bus.sp_in = 8'h00; bus.push_data = 8'hEE;
    bus.pc_plus1 = 8'hEE; bus.target = 8'hEE; bus.flags_in = 4'h5; bus.rd = 2'd3;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.done && n < 12);
    rdy_done = bus.op_ready;
    @(negedge clk);
    rdy_after = bus.op_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.op_valid = 1'b0; bus.op = 3'd0; bus.sp_in = 8'h00; bus.push_data = 8'h00;
    bus.pc_plus1 = 8'h00; bus.target = 8'h00; bus.flags_in = 4'h0; bus.rd = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL reset op_ready: got %b need 1", bus.op_ready);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.sp_value, bus.sp_write_enable,
         bus.rd_we, bus.rd_wa, bus.rd_data, bus.pc_load, bus.pc_value, bus.flags_load,
         bus.flags_value, bus.done, bus.err} !== '0) begin
      errors++; $display("FAIL reset outputs: got nonzero output, need all 0");
    end
    rst = 1'b1;
    @(negedge clk);
    obs_q.delete();
  endtask

  task automatic test_push_pop();
    ev_t e, o;
    logic r0, r1;
    exp_q.push_back(ev(K_MW, 1, 8'hFF, 8'h5A));
    exp_q.push_back(ev(K_SP, 2, 8'hFE, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd0, 8'hFF, 8'h5A, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    checks++;
    if (mem[8'hFF] !== 8'h5A) begin
      errors++; $display("FAIL push mem[FF]: got %h need 5a", mem[8'hFF]);
    end
    exp_q.push_back(ev(K_MR, 1, 8'hFF, 8'h00));
    exp_q.push_back(ev(K_SP, 2, 8'hFF, 8'h00));
    exp_q.push_back(ev(K_RD, 3, 8'h01, 8'h5A));
    exp_q.push_back(ev(K_DN, 3, 8'h00, 8'h00));
    issue(3'd1, 8'hFE, 8'h00, 8'h00, 8'h00, 4'h0, 2'd1, r0, r1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL push_pop event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL push_pop extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_faults();
    ev_t e, o;
    logic r0, r1;
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd1, 8'hFF, 8'h00, 8'h00, 8'h00, 4'h0, 2'd2, r0, r1);  // POP on empty stack
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd1, 8'hF0, 8'h00, 8'h00, 8'h00, 4'h0, 2'd3, r0, r1);  // POP into SP register
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd6, 8'hF0, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd3, 8'hFF, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd5, 8'hFE, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL faults event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL faults extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_call_ret();
    ev_t e, o;
    logic r0, r1;
    exp_q.push_back(ev(K_MW, 1, 8'hFE, 8'h13));
    exp_q.push_back(ev(K_SP, 2, 8'hFD, 8'h00));
    exp_q.push_back(ev(K_PC, 2, 8'h40, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd2, 8'hFE, 8'h00, 8'h13, 8'h40, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_MR, 1, 8'hFE, 8'h00));
    exp_q.push_back(ev(K_SP, 2, 8'hFE, 8'h00));
    exp_q.push_back(ev(K_PC, 2, 8'h13, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd3, 8'hFD, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL call_ret event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL call_ret extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_int_rti();
    ev_t e, o;
    logic r0, r1;
    exp_q.push_back(ev(K_MW, 1, 8'hFF, 8'h31));
    exp_q.push_back(ev(K_MW, 2, 8'hFE, 8'h0A));
    exp_q.push_back(ev(K_MR, 3, 8'h01, 8'h00));
    exp_q.push_back(ev(K_SP, 4, 8'hFD, 8'h00));
    exp_q.push_back(ev(K_PC, 4, 8'h20, 8'h00));
    exp_q.push_back(ev(K_DN, 4, 8'h00, 8'h00));
    issue(3'd4, 8'hFF, 8'h00, 8'h31, 8'h00, 4'hA, 2'd0, r0, r1);
    checks++;
    if (mem[8'hFE] !== 8'h0A) begin
      errors++; $display("FAIL int saved flags mem[FE]: got %h need 0a", mem[8'hFE]);
    end
    exp_q.push_back(ev(K_MR, 1, 8'hFE, 8'h00));
    exp_q.push_back(ev(K_MR, 2, 8'hFF, 8'h00));
    exp_q.push_back(ev(K_SP, 3, 8'hFF, 8'h00));
    exp_q.push_back(ev(K_PC, 3, 8'h31, 8'h00));
    exp_q.push_back(ev(K_FL, 3, 8'h0A, 8'h00));
    exp_q.push_back(ev(K_DN, 3, 8'h00, 8'h00));
    issue(3'd5, 8'hFD, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL int_rti event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL int_rti extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_limits();
    ev_t e, o;
    logic r0, r1;
    exp_q.push_back(ev(K_MW, 1, 8'h80, 8'h77));
    exp_q.push_back(ev(K_SP, 2, 8'h7F, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd0, 8'h80, 8'h77, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd0, 8'h7F, 8'h66, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd2, 8'h7F, 8'h00, 8'h09, 8'h50, 4'h0, 2'd0, r0, r1);
    exp_q.push_back(ev(K_DN, 1, 8'h01, 8'h00));
    issue(3'd4, 8'h80, 8'h00, 8'h44, 8'h00, 4'h3, 2'd0, r0, r1);
    exp_q.push_back(ev(K_MW, 1, 8'h81, 8'h44));
    exp_q.push_back(ev(K_MW, 2, 8'h80, 8'h03));
    exp_q.push_back(ev(K_MR, 3, 8'h01, 8'h00));
    exp_q.push_back(ev(K_SP, 4, 8'h7F, 8'h00));
    exp_q.push_back(ev(K_PC, 4, 8'h20, 8'h00));
    exp_q.push_back(ev(K_DN, 4, 8'h00, 8'h00));
    issue(3'd4, 8'h81, 8'h00, 8'h44, 8'h00, 4'h3, 2'd0, r0, r1);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL limits event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL limits extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    ev_t e, o;
    logic rdy_done, rdy_after, r0, r1;
    int t0, t1;
    t0 = cyc_cnt;
    exp_q.push_back(ev(K_MW, 1, 8'hFF, 8'h11));
    exp_q.push_back(ev(K_SP, 2, 8'hFE, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd0, 8'hFF, 8'h11, 8'h00, 8'h00, 4'h0, 2'd0, rdy_done, rdy_after);
    t1 = cyc_cnt;
    exp_q.push_back(ev(K_MW, 1, 8'hFE, 8'h22));
    exp_q.push_back(ev(K_SP, 2, 8'hFD, 8'h00));
    exp_q.push_back(ev(K_DN, 2, 8'h00, 8'h00));
    issue(3'd0, 8'hFE, 8'h22, 8'h00, 8'h00, 4'h0, 2'd0, r0, r1);
    checks++;
    if (rdy_done !== 1'b0) begin
      errors++; $display("FAIL b2b op_ready at done: got %b need 0", rdy_done);
    end
    checks++;
    if (rdy_after !== 1'b1) begin
      errors++; $display("FAIL b2b op_ready after done: got %b need 1", rdy_after);
    end
    checks++;
    if (t1 - t0 != 3) begin
      errors++; $display("FAIL b2b issue spacing: got %0d need 3", t1 - t0);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL b2b event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL b2b extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  task automatic test_reset_mid_op();
    ev_t e, o;
    exp_q.push_back(ev(K_MW, 1, 8'hFF, 8'h31));
    bus.op_valid = 1'b1; bus.op = 3'd4; bus.sp_in = 8'hFF; bus.pc_plus1 = 8'h31;
    bus.flags_in = 4'hA; bus.rd = 2'd0;
    @(posedge clk); #1;
    bus.op_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.op_ready !== 1'b1) begin
      errors++; $display("FAIL midreset op_ready: got %b need 1", bus.op_ready);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.mem_we, bus.mem_re, bus.sp_value, bus.sp_write_enable,
         bus.rd_we, bus.rd_wa, bus.rd_data, bus.pc_load, bus.pc_value, bus.flags_load,
         bus.flags_value, bus.done, bus.err} !== '0) begin
      errors++; $display("FAIL midreset outputs: got nonzero output, need all 0");
    end
    repeat (6) @(negedge clk);
    checks++;
    if (mem[8'hFF] !== 8'h31) begin
      errors++; $display("FAIL midreset mem[FF]: got %h need 31", mem[8'hFF]);
    end
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      o = (obs_q.size() != 0) ? obs_q.pop_front() : '0;
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL midreset event: got k%0d c%0d a%h b%h need k%0d c%0d a%h b%h",
                 o.k, o.c, o.a, o.b, e.k, e.c, e.a, e.b);
      end
    end
    checks++;
    if (obs_q.size() != 0) begin
      errors++; $display("FAIL midreset extra events: got %0d need 0", obs_q.size());
      obs_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_faults();
    test_call_ret();
    test_int_rti();
    test_limits();
    test_back_to_back();
    test_reset_mid_op();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout need completion");
    $fatal(1, "watchdog expired");
  end
endmodule
